// File: rtl/usb_ftdi_fsi_pkg.sv
// -----------------------------------------------------------------------------
// usb_ftdi_fsi_pkg
//
// Shared types and helpers for the FTDI fast-serial-interface bridge.
//   frame_bits()  : number of FSI bits per frame for a given channel width
//                   (start bit + 8 data bits + channel bits)
//   rx_state_e    : receive FSM states
//   tx_state_e    : transmit FSM states
// -----------------------------------------------------------------------------
package usb_ftdi_fsi_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_HOLD
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    // Usable in localparam context: start bit, 8 data bits, channel bits.
    function automatic int frame_bits(input int channel_bits);
        return 9 + channel_bits;
    endfunction

endpackage

// File: rtl/usb_ftdi_fsi_fifo.sv
// -----------------------------------------------------------------------------
// usb_ftdi_fsi_fifo
//
// Synchronous first-word-fall-through FIFO holding outbound {channel, byte}
// words for the FSI transmitter.
//
// Parameters:
//   WIDTH       word width (8 + channel bits)
//   DEPTH_BITS  log2 of the number of entries
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_push, i_push_data write request and word
//   i_pop               consume the head word
//   o_pop_data          head word (valid while !o_empty)
//   o_full              registered full flag
//   o_empty             empty flag
//
// A push while full is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module usb_ftdi_fsi_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_BITS = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic [DEPTH_BITS:0]   count_next;
    logic                  full_q;
    logic                  do_push;
    logic                  do_pop;

    assign o_empty    = (count == '0);
    assign o_full     = full_q;
    assign o_pop_data = mem[rd_ptr];

    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!full_q || do_pop);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_q <= (count_next == DEPTH_CNT);
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/usb_ftdi_fsi_mc.sv
// -----------------------------------------------------------------------------
// usb_ftdi_fsi_mc
//
// FTDI FT232H fast-serial-interface bridge with programmable FSI clock
// divider, multi-bit channel IDs and a TX FIFO.
//
// Frame (both directions): start bit 0, 8 data bits LSB first, CHANNEL_BITS
// channel bits LSB first. Idle line level is 1. SI changes on the falling
// FSI clock edge; SO is sampled just before the rising edge.
//
// Parameters:
//   CLK_DIV             i_clk cycles per FSI clock half-period (>=1)
//   CHANNEL_BITS        channel-ID bits per frame (1..4)
//   TX_FIFO_DEPTH_BITS  log2 TX FIFO depth (1..6)
//
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   o_ftdi_clk, o_ftdi_si           FSI clock and serial data to FTDI
//   i_ftdi_so, i_ftdi_cts           serial data and clear-to-send from FTDI
//   o_rx_valid/i_rx_ready           RX frame handshake
//   o_rx_channel, o_rx_data         RX frame contents
//   o_tx_ready/i_tx_valid           TX FIFO write handshake
//   i_tx_channel, i_tx_data         TX frame contents
//
// Optional build macro USB_FTDI_FSI_STATS_EN adds:
//   o_rx_contention_count[7:0]      RX frames discarded due to start contention
//   o_rx_stall_cycles[15:0]         i_clk cycles the FSI clock was halted
// Both saturate at all-ones.
// -----------------------------------------------------------------------------
module usb_ftdi_fsi_mc
    import usb_ftdi_fsi_pkg::*;
#(
    parameter int CLK_DIV            = 1,
    parameter int CHANNEL_BITS       = 1,
    parameter int TX_FIFO_DEPTH_BITS = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    output logic                    o_ftdi_clk,
    output logic                    o_ftdi_si,
    input  logic                    i_ftdi_so,
    input  logic                    i_ftdi_cts,
    input  logic                    i_rx_ready,
    output logic                    o_rx_valid,
    output logic [CHANNEL_BITS-1:0] o_rx_channel,
    output logic [7:0]              o_rx_data,
    output logic                    o_tx_ready,
    input  logic                    i_tx_valid,
    input  logic [CHANNEL_BITS-1:0] i_tx_channel,
    input  logic [7:0]              i_tx_data
`ifdef USB_FTDI_FSI_STATS_EN
    ,
    output logic [7:0]              o_rx_contention_count,
    output logic [15:0]             o_rx_stall_cycles
`endif
);

    localparam int N  = frame_bits(CHANNEL_BITS);
    localparam int FW = N - 1;                        // payload bits after the start bit
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(N);

    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] RX_LAST    = BW'(FW - 1); // payload sample index of the last bit
    localparam logic [BW-1:0] TX_LAST    = BW'(FW);     // frame bit index of the last channel bit

    // ---------------------------------------------------------------- clocking
    logic [PW-1:0] phase_cnt;
    logic          phase_end;
    logic          drive_pos;
    logic          halt;
    logic          drive_tick;
    logic          sample_tick;

    assign phase_end   = (phase_cnt == PHASE_LAST);
    assign drive_pos   = o_ftdi_clk && phase_end;
    // The clock parks high while a received frame waits for its consumer.
    assign halt        = drive_pos && o_rx_valid && !i_rx_ready;
    assign drive_tick  = drive_pos && !halt;
    assign sample_tick = !o_ftdi_clk && phase_end;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_cnt  <= '0;
            o_ftdi_clk <= 1'b1;
        end else if (!halt) begin
            if (phase_end) begin
                phase_cnt  <= '0;
                o_ftdi_clk <= !o_ftdi_clk;
            end else begin
                phase_cnt  <= phase_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [FW-1:0] fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          tx_start;

    assign o_tx_ready = !fifo_full;
    assign fifo_push  = i_tx_valid && o_tx_ready;

    usb_ftdi_fsi_fifo #(
        .WIDTH      (FW),
        .DEPTH_BITS (TX_FIFO_DEPTH_BITS)
    ) u_tx_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (fifo_push),
        .i_push_data ({i_tx_channel, i_tx_data}),
        .i_pop       (tx_start),
        .o_pop_data  (fifo_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // ---------------------------------------------------------------- TX FSM
    tx_state_e     tx_state;
    logic [BW-1:0] tx_cnt;
    logic [FW-1:0] tx_shift;
    logic          tx_mid_frame;
    logic          tx_can_start;
    logic          tx_start_bit_active;
    rx_state_e     rx_state;

    assign tx_mid_frame        = (tx_state == TX_SHIFT) && (tx_cnt != TX_LAST);
    assign tx_can_start        = !fifo_empty && i_ftdi_cts && (rx_state == RX_IDLE);
    // A new frame may start on the same tick the previous one releases the line.
    assign tx_start            = drive_tick && !tx_mid_frame && tx_can_start;
    assign tx_start_bit_active = (tx_state == TX_SHIFT) && (tx_cnt == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_shift  <= '0;
            o_ftdi_si <= 1'b1;
        end else if (drive_tick) begin
            if (tx_mid_frame) begin
                o_ftdi_si <= tx_shift[0];
                tx_shift  <= {1'b0, tx_shift[FW-1:1]};
                tx_cnt    <= tx_cnt + 1'b1;
            end else if (tx_can_start) begin
                o_ftdi_si <= 1'b0;
                tx_shift  <= fifo_data;
                tx_cnt    <= '0;
                tx_state  <= TX_SHIFT;
            end else begin
                o_ftdi_si <= 1'b1;
                tx_state  <= TX_IDLE;
            end
        end
    end

    // ---------------------------------------------------------------- RX FSM
    logic [BW-1:0] rx_cnt;
    logic [FW-1:0] rx_shift;
    logic [FW-1:0] rx_word;
    logic          rx_contention;

    // Bits enter at the top so the first payload bit lands in bit 0.
    assign rx_word = {i_ftdi_so, rx_shift[FW-1:1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_shift      <= '0;
            rx_contention <= 1'b0;
            o_rx_valid    <= 1'b0;
            o_rx_data     <= '0;
            o_rx_channel  <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (sample_tick && !i_ftdi_so) begin
                        rx_state      <= RX_SHIFT;
                        rx_cnt        <= '0;
                        // Both directions started together: the RX frame is unreliable.
                        rx_contention <= tx_start_bit_active;
                    end
                end
                RX_SHIFT: begin
                    if (sample_tick) begin
                        rx_shift <= rx_word;
                        if (rx_cnt == RX_LAST) begin
                            if (rx_contention) begin
                                rx_state <= RX_IDLE;
                            end else begin
                                o_rx_data    <= rx_word[7:0];
                                o_rx_channel <= rx_word[FW-1:8];
                                o_rx_valid   <= 1'b1;
                                rx_state     <= RX_HOLD;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                RX_HOLD: begin
                    if (i_rx_ready) begin
                        o_rx_valid <= 1'b0;
                        rx_state   <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state   <= RX_IDLE;
                    o_rx_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef USB_FTDI_FSI_STATS_EN
    // ---------------------------------------------------------------- statistics
    logic rx_discard;

    assign rx_discard = (rx_state == RX_SHIFT) && sample_tick &&
                        (rx_cnt == RX_LAST) && rx_contention;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rx_contention_count <= '0;
            o_rx_stall_cycles     <= '0;
        end else begin
            if (rx_discard && (o_rx_contention_count != '1))
                o_rx_contention_count <= o_rx_contention_count + 1'b1;
            if (halt && (o_rx_stall_cycles != '1))
                o_rx_stall_cycles <= o_rx_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_ftdi_fsi_mc.sv
// -----------------------------------------------------------------------------
// tb_usb_ftdi_fsi_mc
//
// Scoreboard bench for usb_ftdi_fsi_mc with CLK_DIV=2, CHANNEL_BITS=2 and a
// 4-deep TX FIFO. Stimulus pushes hand-computed expected frames into queues;
// independent monitors decode SI and the RX handshake and compare.
// Honours USB_FTDI_FSI_STATS_EN for the optional counter ports.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_ftdi_fsi_mc;

    localparam int CLK_DIV      = 2;
    localparam int CHANNEL_BITS = 2;
    localparam int DEPTH_BITS   = 2;
    localparam int N            = 11;
    localparam int BIT_CYC      = 2 * CLK_DIV;

    logic                    i_clk = 1'b0;
    logic                    i_reset;
    logic                    o_ftdi_clk;
    logic                    o_ftdi_si;
    logic                    i_ftdi_so;
    logic                    i_ftdi_cts;
    logic                    i_rx_ready;
    logic                    o_rx_valid;
    logic [CHANNEL_BITS-1:0] o_rx_channel;
    logic [7:0]              o_rx_data;
    logic                    o_tx_ready;
    logic                    i_tx_valid;
    logic [CHANNEL_BITS-1:0] i_tx_channel;
    logic [7:0]              i_tx_data;
`ifdef USB_FTDI_FSI_STATS_EN
    logic [7:0]              o_rx_contention_count;
    logic [15:0]             o_rx_stall_cycles;
`endif

    usb_ftdi_fsi_mc #(
        .CLK_DIV            (CLK_DIV),
        .CHANNEL_BITS       (CHANNEL_BITS),
        .TX_FIFO_DEPTH_BITS (DEPTH_BITS)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .o_ftdi_clk   (o_ftdi_clk),
        .o_ftdi_si    (o_ftdi_si),
        .i_ftdi_so    (i_ftdi_so),
        .i_ftdi_cts   (i_ftdi_cts),
        .i_rx_ready   (i_rx_ready),
        .o_rx_valid   (o_rx_valid),
        .o_rx_channel (o_rx_channel),
        .o_rx_data    (o_rx_data),
        .o_tx_ready   (o_tx_ready),
        .i_tx_valid   (i_tx_valid),
        .i_tx_channel (i_tx_channel),
        .i_tx_data    (i_tx_data)
`ifdef USB_FTDI_FSI_STATS_EN
        ,
        .o_rx_contention_count (o_rx_contention_count),
        .o_rx_stall_cycles     (o_rx_stall_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [10:0] bits;
        bit          b2b;
    } tx_exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------------------------------------------------------- TX monitor
    bit          mon_in_frame = 0;
    int          mon_idx;
    int          mon_since;
    int          mon_wmax;
    int          mon_wmin;
    int          mon_idle = 100;
    int          mon_gap;
    logic        mon_prev_clk = 1'b1;
    logic [10:0] mon_bits;

    initial begin
        tx_exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                mon_in_frame = 0;
                mon_prev_clk = 1'b1;
                mon_since    = 0;
                mon_idle     = 100;
            end else begin
                mon_since++;
                if (mon_prev_clk && !o_ftdi_clk) begin
                    if (mon_in_frame) begin
                        if (mon_since > mon_wmax) mon_wmax = mon_since;
                        if (mon_since < mon_wmin) mon_wmin = mon_since;
                        mon_bits[mon_idx] = o_ftdi_si;
                        mon_idx++;
                        if (mon_idx == N) begin
                            mon_in_frame = 0;
                            mon_idle     = 0;
                            if (tx_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL tx_unexpected_frame: actual 0x%0h required none", mon_bits);
                            end else begin
                                e = tx_q.pop_front();
                                check("tx_frame_bits", 32'(mon_bits), 32'(e.bits));
                                check("tx_bit_width_max", mon_wmax, BIT_CYC);
                                check("tx_bit_width_min", mon_wmin, BIT_CYC);
                                if (e.b2b) check("tx_b2b_gap", mon_gap, 0);
                            end
                        end
                    end else if (!o_ftdi_si) begin
                        mon_in_frame = 1;
                        mon_idx      = 1;
                        mon_bits     = '0;
                        mon_wmax     = 0;
                        mon_wmin     = 1000;
                        mon_gap      = mon_idle;
                    end else begin
                        mon_idle++;
                    end
                    mon_since = 0;
                end
                mon_prev_clk = o_ftdi_clk;
            end
        end
    end

    // ---------------------------------------------------------------- RX monitor
    initial begin
        rx_exp_t r;
        forever begin
            @(negedge i_clk);
            if (!i_reset && o_rx_valid && i_rx_ready) begin
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected_frame: actual data 0x%0h ch %0d required none",
                             o_rx_data, o_rx_channel);
                end else begin
                    r = rx_q.pop_front();
                    check("rx_data", 32'(o_rx_data), 32'(r.data));
                    check("rx_channel", 32'(o_rx_channel), 32'(r.ch));
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_edge(input bit rising);
        logic p;
        bit   ok;
        p  = o_ftdi_clk;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (rising ? (!p && o_ftdi_clk) : (p && !o_ftdi_clk)) begin
                ok = 1;
                break;
            end
            p = o_ftdi_clk;
        end
        if (!ok) timeout(rising ? "wait_fsi_rise" : "wait_fsi_fall");
    endtask

    task automatic wait_tx_start();
        bit ok;
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            wait_edge(1'b0);
            if (!o_ftdi_si) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("wait_tx_start_bit");
    endtask

    task automatic push_tx(input logic [7:0] d, input logic [1:0] ch, input bit expect_it, input bit b2b);
        int n;
        n = 0;
        while (!o_tx_ready && n < 200) begin
            tick();
            n++;
        end
        if (!o_tx_ready) timeout("push_tx_ready");
        if (expect_it) tx_q.push_back('{{ch, d, 1'b0}, b2b});
        i_tx_valid   = 1'b1;
        i_tx_data    = d;
        i_tx_channel = ch;
        tick();
        i_tx_valid   = 1'b0;
    endtask

    // Drives one SO frame, changing SO right after each falling FSI edge.
    task automatic drive_so_frame(input logic [7:0] d, input logic [1:0] ch, input bit aligned);
        logic [10:0] f;
        f = {ch, d, 1'b0};
        for (int i = 0; i < N; i++) begin
            if (!(i == 0 && aligned)) wait_edge(1'b0);
            i_ftdi_so = f[i];
        end
        wait_edge(1'b1);
        i_ftdi_so = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((tx_q.size() != 0 || rx_q.size() != 0 || mon_in_frame) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) timeout("drain");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int cnt;
        int lat;

        i_reset      = 1'b1;
        i_ftdi_so    = 1'b1;
        i_ftdi_cts   = 1'b1;
        i_rx_ready   = 1'b1;
        i_tx_valid   = 1'b0;
        i_tx_data    = '0;
        i_tx_channel = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ftdi_clk", 32'(o_ftdi_clk), 1);
        check("rst_ftdi_si", 32'(o_ftdi_si), 1);
        check("rst_rx_valid", 32'(o_rx_valid), 0);
        check("rst_tx_ready", 32'(o_tx_ready), 1);
        check("rst_rx_data", 32'(o_rx_data), 0);
        check("rst_rx_channel", 32'(o_rx_channel), 0);
        i_reset = 1'b0;
        repeat (2) tick();

        // 1) 0xA5 on channel 3: SI = 0,1,0,1,0,0,1,0,1,1,1
        tx_q.push_back('{11'h74A, 1'b0});
        push_tx(8'hA5, 2'd3, 1'b0, 1'b0);
        wait_drain();
        check("t1_fifo_empty_ready", 32'(o_tx_ready), 1);

        // 2) SO frame 0x3C on channel 1 with consumer ready
        rx_q.push_back('{8'h3C, 2'd1});
        drive_so_frame(8'h3C, 2'd1, 1'b0);
        repeat (10) tick();
        check("t2_rx_consumed", rx_q.size(), 0);

        // 3) RX backpressure halts the FSI clock and blocks TX
        i_rx_ready = 1'b0;
        rx_q.push_back('{8'h5A, 2'd2});
        drive_so_frame(8'h5A, 2'd2, 1'b0);
        cnt = 0;
        while (!o_rx_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("t3_rx_valid", 32'(o_rx_valid), 1);
        push_tx(8'h81, 2'd0, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (!o_ftdi_clk || !o_ftdi_si) cnt++;
        end
        check("t3_halt_clk_or_si_low", cnt, 0);
        check("t3_rx_valid_held", 32'(o_rx_valid), 1);
`ifdef USB_FTDI_FSI_STATS_EN
        check("t3_stall_cycles_nonzero", 32'(o_rx_stall_cycles != 0), 1);
`endif
        i_rx_ready = 1'b1;
        lat = 0;
        while (o_ftdi_clk && lat < 20) begin
            tick();
            lat++;
        end
        check("t3_resume_within_2div", 32'(lat <= BIT_CYC), 1);
        wait_drain();

        // 4) SO start bit in the same period as the TX start bit
        push_tx(8'h96, 2'd2, 1'b1, 1'b0);
        wait_tx_start();
        drive_so_frame(8'hC3, 2'd1, 1'b1);
        wait_drain();
        repeat (40) tick();
        check("t4_rx_valid_low", 32'(o_rx_valid), 0);
`ifdef USB_FTDI_FSI_STATS_EN
        check("t4_contention_count", 32'(o_rx_contention_count), 1);
`endif

        // 5) Fill FIFO with CTS low, then release for back-to-back frames
        i_ftdi_cts = 1'b0;
        push_tx(8'h01, 2'd0, 1'b1, 1'b0);
        push_tx(8'hFE, 2'd1, 1'b1, 1'b1);
        push_tx(8'h7F, 2'd2, 1'b1, 1'b1);
        check("t5_ready_after_3", 32'(o_tx_ready), 1);
        push_tx(8'h80, 2'd3, 1'b1, 1'b1);
        check("t5_ready_after_4", 32'(o_tx_ready), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!o_ftdi_si) cnt++;
        end
        check("t5_si_idle_while_cts_low", cnt, 0);
        i_ftdi_cts = 1'b1;
        wait_drain();
        check("t5_ready_after_drain", 32'(o_tx_ready), 1);

        // 6) Reset in the middle of a TX frame
        push_tx(8'h11, 2'd0, 1'b0, 1'b0);
        push_tx(8'h22, 2'd1, 1'b0, 1'b0);
        wait_tx_start();
        repeat (3) wait_edge(1'b0);
        i_reset = 1'b1;
        tick();
        check("t6_rst_si", 32'(o_ftdi_si), 1);
        check("t6_rst_ftdi_clk", 32'(o_ftdi_clk), 1);
        check("t6_rst_fifo_empty", 32'(o_tx_ready), 1);
        tick();
        i_reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!o_ftdi_si) cnt++;
        end
        check("t6_no_stale_tx", cnt, 0);
        push_tx(8'h5C, 2'd2, 1'b1, 1'b0);
        wait_drain();

        repeat (20) tick();
        check("end_tx_queue_empty", tx_q.size(), 0);
        check("end_rx_queue_empty", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_ftdi_fsi_mc.md
# usb_ftdi_fsi_mc

Parametrised FTDI fast-serial-interface (FSI) bridge. It generates the FSI clock with a programmable divider, carries multi-bit channel IDs, and buffers outbound bytes in a TX FIFO. It sits between the USB core's byte streams and the FT232H pins, replacing the fixed 1-bit-channel, single-byte variant. RX backpressure stalls the FSI clock; RX/TX start-bit contention is detected and handled.

## Interface
- CLK_DIV, 1, i_clk cycles per FSI clock half-period (≥1; 1 = toggle every cycle)
- CHANNEL_BITS, 1, channel-ID bits per frame (1..4)
- TX_FIFO_DEPTH_BITS, 2, log2 TX FIFO depth (1..6)
- i_clk  in  1  sole clock
- i_reset  in  1  asynchronous, active-high reset
- o_ftdi_clk  out  1  FSI clock to FTDI
- o_ftdi_si  out  1  serial data to FTDI
- i_ftdi_so  in  1  serial data from FTDI (pre-synchronised)
- i_ftdi_cts  in  1  high = FTDI can accept a frame
- i_rx_ready  in  1  RX consumer ready
- o_rx_valid  out  1  RX frame held
- o_rx_channel  out  CHANNEL_BITS  RX channel ID
- o_rx_data  out  8  RX byte
- o_tx_ready  out  1  TX FIFO not full
- i_tx_valid  in  1  TX byte offered
- i_tx_channel  in  CHANNEL_BITS  TX channel ID
- i_tx_data  in  8  TX byte

## Operation
- Frame on both lines: start bit 0, 8 data bits LSB first, CHANNEL_BITS channel bits LSB first; N = 9+CHANNEL_BITS bits. Idle line = 1.
- Phase counter counts CLK_DIV cycles per half-period. Drive tick = last cycle of the high phase; o_ftdi_clk falls next cycle, and SI updates on that edge. Sample tick = last cycle of the low phase; SO is sampled there.
- Clock halt: at a drive tick with o_rx_valid=1 and i_rx_ready=0, o_ftdi_clk stays high and the counter holds. It resumes at the drive tick after the handshake.
- RX FSM IDLE→SHIFT→HOLD.
  - IDLE: SO=0 at a sample tick → SHIFT. Latch contention flag = TX start bit driven in this same bit period.
  - SHIFT: shift N-1 bits.
  - On the last bit: if there is no contention, load o_rx_data/o_rx_channel, set o_rx_valid, go to HOLD. If there is contention, discard and go to IDLE.
  - HOLD: o_rx_valid stays high until i_rx_ready; RX→IDLE in the cycle of the handshake.
- TX FSM IDLE→SHIFT.
  - Start at a drive tick if: FIFO not empty, i_ftdi_cts=1, RX in IDLE, and clock not halted. On start, pop the FIFO and drive 0.
  - Each following drive tick shifts the next bit.
  - After the last channel bit's period, SI returns to 1 at the next drive tick. TX→IDLE. Back-to-back frames may start at that same tick.
- FIFO: write when i_tx_valid && o_tx_ready. A simultaneous push and pop on a full FIFO is legal; o_tx_ready is registered from the count as of the previous cycle.

## Timing
- Reset values:
  - o_ftdi_clk=1, o_ftdi_si=1, o_rx_valid=0, o_tx_ready=1
  - o_rx_data=0, o_rx_channel=0
  - FIFO empty, both FSMs IDLE, phase counter 0
- Reset mid-frame aborts both directions immediately. A partial RX frame is never presented.
- TX latency, write to SI start bit: ≤2·CLK_DIV+2 cycles when idle and CTS high.
- RX latency, last sample tick to o_rx_valid: 1 cycle.
- FSI bit period = 2·CLK_DIV i_clk cycles.
- CTS is checked only at start; deassertion mid-frame does not stop the frame.

## Configuration
- USB_FTDI_FSI_STATS_EN defined: adds outputs o_rx_contention_count[7:0] and o_rx_stall_cycles[15:0]. Both saturate at all-ones and reset to 0.
  - o_rx_contention_count increments once per discarded RX frame.
  - o_rx_stall_cycles increments each i_clk cycle the FSI clock is halted.
- Undefined: ports and counters are absent. Functional behaviour is identical.

## Structure
- Package usb_ftdi_fsi_pkg holds:
  - localparam function frame_bits(CHANNEL_BITS)
  - enums rx_state_e {RX_IDLE, RX_SHIFT, RX_HOLD} and tx_state_e {TX_IDLE, TX_SHIFT}
- One sub-module, usb_ftdi_fsi_fifo: synchronous FIFO, width 8+CHANNEL_BITS, depth 2^TX_FIFO_DEPTH_BITS, with full/empty flags.

## Test plan
- CLK_DIV=2, CHANNEL_BITS=2: push 0xA5 on ch 3 → SI shows 0,1,0,1,0,0,1,0,1,1,1, each bit 4 cycles wide; FIFO empty afterwards.
- Drive SO frame 0x3C on ch 1, i_rx_ready=1 → o_rx_valid pulses once with data 0x3C, channel 1.
- Hold i_rx_ready=0 after an RX frame → o_ftdi_clk stays high and a pending TX does not start. Raise ready → clock resumes within 2·CLK_DIV cycles and TX starts.
- Start SO frame in the same bit period as the TX start bit → RX discarded (no o_rx_valid), TX completes intact, contention count = 1 (with STATS_EN).
- Fill FIFO (depth 4) with i_ftdi_cts=0 → o_tx_ready=0 after the 4th write and no SI activity. Raise CTS → 4 back-to-back frames with no idle gap.
- Assert i_reset mid-TX frame → SI=1, o_ftdi_clk=1, FIFO empty in the cycle after assertion; the next frame after release is clean.
